// File: rtl/pulse_stretch_pkg.sv
// rtl/pulse_stretch_pkg.sv - shared state enum and default parameters for pulse_stretch
//
// Purpose : common types and constants for pulse_stretch and its sub-module.
// Contents: state_e (IDLE, HIGH, GAP), default HIGH_CYC / GAP_CYC / QW values,
//           max_int helper used to size the phase counter.
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int DEF_HIGH_CYC = 4;
   localparam int DEF_GAP_CYC  = 2;
   localparam int DEF_QW       = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered rising-edge detector for a level input
//
// Purpose: emits a one-cycle pulse on rise, one cycle after d goes 0->1.
// Ports  : clk   - clock
//          rst_n - asynchronous active-low reset
//          d     - level input
//          rise  - registered rising-edge pulse
module edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic d_q;
   logic rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q    <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         d_q    <= d;
         rise_q <= d & ~d_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - request pulse stretcher with pending queue and mandatory gap
//
// Purpose : each accepted request produces HIGH_CYC cycles of level_o = 1
//           followed by GAP_CYC low cycles; requests arriving while busy are
//           counted in a saturating pending counter.
// Config  : PULSE_STRETCH_EDGE_EN - when defined, pulse_i is a level and only
//           its (registered) rising edge counts as a request.
// Ports   : clk       - clock, rising edge
//           rst_n     - asynchronous active-low reset
//           pulse_i   - request input
//           clr_i     - synchronous flush/abort
//           level_o   - registered stretched output
//           busy_o    - state is not IDLE
//           pending_o - accepted requests not yet started
//           ovf_o     - sticky dropped-request flag
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int HIGH_CYC = DEF_HIGH_CYC,
   parameter int GAP_CYC  = DEF_GAP_CYC,
   parameter int QW       = DEF_QW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pulse_i,
   input  logic          clr_i,
   output logic          level_o,
   output logic          busy_o,
   output logic [QW-1:0] pending_o,
   output logic          ovf_o
);

   // +1 keeps the width non-zero when both phases are a single cycle.
   localparam int CW = $clog2(max_int(HIGH_CYC, GAP_CYC) + 1);

   localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [QW-1:0] PEND_ONE  = QW'(1);
   localparam logic [QW-1:0] PEND_MAX  = {QW{1'b1}};

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [QW-1:0]   pend_q, pend_d;
   logic            ovf_q, ovf_d;
   logic            level_q, level_d;

   logic            req;
   logic            start;
   logic            consume;
   logic            dec;
   logic            inc;

`ifdef PULSE_STRETCH_EDGE_EN
   edge_det u_edge_det (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pulse_i),
      .rise  (req)
   );
`else
   assign req = pulse_i;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      start   = 1'b0;
      consume = 1'b0;
      dec     = 1'b0;

      case (state_q)
         IDLE: begin
            // Queued work takes precedence; a live request is then counted.
            if (pend_q != '0) begin
               start = 1'b1;
               dec   = 1'b1;
            end else if (req) begin
               start   = 1'b1;
               consume = 1'b1;
            end
         end
         HIGH: begin
            if (cnt_q == HIGH_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               if (pend_q != '0) begin
                  start = 1'b1;
                  dec   = 1'b1;
               end else if (req) begin
                  start   = 1'b1;
                  consume = 1'b1;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (start) begin
         state_d = HIGH;
         cnt_d   = '0;
      end

      // A request not started this edge must be queued (or dropped if full).
      inc = req & ~consume;
      if (inc && !dec) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PEND_ONE;
         end
      end else if (dec && !inc) begin
         pend_d = pend_q - PEND_ONE;
      end

      if (clr_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         pend_d  = '0;
         ovf_d   = 1'b0;
      end

      level_d = (state_d == HIGH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         level_q <= level_d;
      end
   end

   assign level_o   = level_q;
   assign busy_o    = (state_q != IDLE);
   assign pending_o = pend_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - self-checking bench for pulse_stretch (default parameters)
module tb_pulse_stretch;

   typedef struct packed {
      logic       lvl;
      logic       busy;
      logic [1:0] pend;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pulse_i;
   logic       clr_i;
   logic       level_o;
   logic       busy_o;
   logic [1:0] pending_o;
   logic       ovf_o;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pulse_stretch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pulse_i   (pulse_i),
      .clr_i     (clr_i),
      .level_o   (level_o),
      .busy_o    (busy_o),
      .pending_o (pending_o),
      .ovf_o     (ovf_o)
   );

   // Leaves the bench at a negedge with reset released.
   task automatic do_reset();
      rst_n   = 1'b0;
      pulse_i = 1'b0;
      clr_i   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one cycle of inputs; returns at the negedge after the sampling edge.
   task automatic cycle(input logic p, input logic c);
      pulse_i = p;
      clr_i   = c;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      pulse_i = 1'b1;
      clr_i   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (level_o !== 1'b0)    begin n_bad++; $display("FAIL reset level_o got %b want 0", level_o); end
      n_cmp++; if (busy_o !== 1'b0)     begin n_bad++; $display("FAIL reset busy_o got %b want 0", busy_o); end
      n_cmp++; if (pending_o !== 2'd0)  begin n_bad++; $display("FAIL reset pending_o got %0d want 0", pending_o); end
      n_cmp++; if (ovf_o !== 1'b0)      begin n_bad++; $display("FAIL reset ovf_o got %b want 0", ovf_o); end
      pulse_i = 1'b0;
   endtask

`ifndef PULSE_STRETCH_EDGE_EN
   task automatic test_single();
      exp_t e;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         e.lvl = (k <= 4); e.busy = (k <= 6); e.pend = 2'd0; e.ovf = 1'b0;
         sb.push_back(e);
      end
      for (int c = 0; c < 10; c++) begin
         cycle(c == 0, 1'b0);
         e = sb.pop_front();
         n_cmp++;
         if ({level_o, busy_o, pending_o, ovf_o} !== e) begin
            n_bad++;
            $display("FAIL single edge %0d: got lvl=%b busy=%b pend=%0d ovf=%b want lvl=%b busy=%b pend=%0d ovf=%b",
                     c + 1, level_o, busy_o, pending_o, ovf_o, e.lvl, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   task automatic test_queue();
      exp_t e;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         e.lvl  = (((k - 1) % 6) < 4) && (k <= 16);
         e.busy = (k <= 18);
         e.pend = (k < 2) ? 2'd0 : (k < 3) ? 2'd1 : (k < 7) ? 2'd2 : (k < 13) ? 2'd1 : 2'd0;
         e.ovf  = 1'b0;
         sb.push_back(e);
      end
      for (int c = 0; c < 20; c++) begin
         cycle(c < 3, 1'b0);
         e = sb.pop_front();
         n_cmp++;
         if ({level_o, busy_o, pending_o, ovf_o} !== e) begin
            n_bad++;
            $display("FAIL queue edge %0d: got lvl=%b busy=%b pend=%0d ovf=%b want lvl=%b busy=%b pend=%0d ovf=%b",
                     c + 1, level_o, busy_o, pending_o, ovf_o, e.lvl, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      int   rises;
      logic prev;
      do_reset();
      rises = 0;
      prev  = 1'b0;
      for (int k = 1; k <= 28; k++) begin
         e.lvl  = (((k - 1) % 6) < 4) && (k <= 22);
         e.busy = (k <= 24);
         e.pend = (k < 2) ? 2'd0 : (k < 3) ? 2'd1 : (k < 4) ? 2'd2 : (k < 7) ? 2'd3 :
                  (k < 13) ? 2'd2 : (k < 19) ? 2'd1 : 2'd0;
         e.ovf  = (k >= 5);
         sb.push_back(e);
      end
      for (int c = 0; c < 28; c++) begin
         cycle(c < 6, 1'b0);
         if (level_o && !prev) rises++;
         prev = level_o;
         e = sb.pop_front();
         n_cmp++;
         if ({level_o, busy_o, pending_o, ovf_o} !== e) begin
            n_bad++;
            $display("FAIL overflow edge %0d: got lvl=%b busy=%b pend=%0d ovf=%b want lvl=%b busy=%b pend=%0d ovf=%b",
                     c + 1, level_o, busy_o, pending_o, ovf_o, e.lvl, e.busy, e.pend, e.ovf);
         end
      end
      n_cmp++;
      if (rises !== 4) begin n_bad++; $display("FAIL overflow high_phases got %0d want 4", rises); end
   endtask

   task automatic test_clear();
      exp_t e;
      do_reset();
      for (int c = 0; c < 8; c++) cycle(c < 6, 1'b0);
      n_cmp++; if (pending_o !== 2'd2) begin n_bad++; $display("FAIL clear pre pending_o got %0d want 2", pending_o); end
      n_cmp++; if (ovf_o !== 1'b1)     begin n_bad++; $display("FAIL clear pre ovf_o got %b want 1", ovf_o); end
      for (int k = 0; k < 4; k++) begin
         e = '0;
         sb.push_back(e);
      end
      for (int c = 0; c < 4; c++) begin
         cycle(c == 0, c == 0);
         e = sb.pop_front();
         n_cmp++;
         if ({level_o, busy_o, pending_o, ovf_o} !== e) begin
            n_bad++;
            $display("FAIL clear step %0d: got lvl=%b busy=%b pend=%0d ovf=%b want all 0",
                     c, level_o, busy_o, pending_o, ovf_o);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      do_reset();
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      n_cmp++; if (level_o !== 1'b1 || pending_o !== 2'd1) begin
         n_bad++; $display("FAIL areset pre got lvl=%b pend=%0d want lvl=1 pend=1", level_o, pending_o);
      end
      pulse_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({level_o, busy_o, pending_o, ovf_o} !== 5'b0) begin
         n_bad++; $display("FAIL areset mid_phase got lvl=%b busy=%b pend=%0d ovf=%b want all 0",
                           level_o, busy_o, pending_o, ovf_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      e = '0;            sb.push_back(e);
      e = '0;            sb.push_back(e);
      e = '0; e.lvl = 1'b1; e.busy = 1'b1; sb.push_back(e);
      for (int c = 0; c < 3; c++) begin
         cycle(c == 2, 1'b0);
         e = sb.pop_front();
         n_cmp++;
         if ({level_o, busy_o, pending_o, ovf_o} !== e) begin
            n_bad++;
            $display("FAIL areset after step %0d: got lvl=%b busy=%b pend=%0d ovf=%b want lvl=%b busy=%b pend=%0d ovf=%b",
                     c, level_o, busy_o, pending_o, ovf_o, e.lvl, e.busy, e.pend, e.ovf);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      for (int k = 1; k <= 14; k++) begin
         e.lvl  = ((k >= 1) && (k <= 4)) || ((k >= 7) && (k <= 10));
         e.busy = (k <= 12);
         e.pend = 2'd0;
         e.ovf  = 1'b0;
         sb.push_back(e);
      end
      for (int c = 0; c < 14; c++) begin
         cycle((c == 0) || (c == 6), 1'b0);
         e = sb.pop_front();
         n_cmp++;
         if ({level_o, busy_o, pending_o, ovf_o} !== e) begin
            n_bad++;
            $display("FAIL b2b edge %0d: got lvl=%b busy=%b pend=%0d ovf=%b want lvl=%b busy=%b pend=%0d ovf=%b",
                     c + 1, level_o, busy_o, pending_o, ovf_o, e.lvl, e.busy, e.pend, e.ovf);
         end
      end
   endtask
`else
   task automatic test_edge_mode();
      exp_t e;
      do_reset();
      for (int k = 1; k <= 14; k++) begin
         e.lvl  = (k >= 2) && (k <= 5);
         e.busy = (k >= 2) && (k <= 7);
         e.pend = 2'd0;
         e.ovf  = 1'b0;
         sb.push_back(e);
      end
      for (int c = 0; c < 14; c++) begin
         cycle(c < 10, 1'b0);
         e = sb.pop_front();
         n_cmp++;
         if ({level_o, busy_o, pending_o, ovf_o} !== e) begin
            n_bad++;
            $display("FAIL edge_mode edge %0d: got lvl=%b busy=%b pend=%0d ovf=%b want lvl=%b busy=%b pend=%0d ovf=%b",
                     c + 1, level_o, busy_o, pending_o, ovf_o, e.lvl, e.busy, e.pend, e.ovf);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifndef PULSE_STRETCH_EDGE_EN
      test_single();
      test_queue();
      test_overflow();
      test_clear();
      test_async_reset();
      test_back_to_back();
`else
      test_edge_mode();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 The block SHALL have parameter HIGH_CYC, default 4, giving the number of cycles level_o is held high per accepted pulse, legal range 1 or more.
REQ-002 The block SHALL have parameter GAP_CYC, default 2, giving the number of mandatory low cycles after each high phase, legal range 1 or more.
REQ-003 The block SHALL have parameter QW, default 2, giving the width of the pending-pulse counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port pulse_i, input, 1 bit, a request pulse sampled at each rising edge of clk.
REQ-007 The block SHALL have port clr_i, input, 1 bit, a synchronous flush and abort request.
REQ-008 The block SHALL have port level_o, output, 1 bit, the registered stretched output.
REQ-009 The block SHALL have port busy_o, output, 1 bit, high whenever state is not IDLE.
REQ-010 The block SHALL have port pending_o, output, QW bits, the count of accepted pulses not yet started.
REQ-011 The block SHALL have port ovf_o, output, 1 bit, a sticky flag for dropped requests.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, HIGH and GAP.
REQ-013 level_o SHALL be 1 exactly when state is HIGH, and SHALL be driven directly from a register.
REQ-014 In IDLE with pending_o = 0, a sampled pulse_i = 1 SHALL move the state to HIGH at that same edge, giving a latency of 1 cycle, and pending_o SHALL remain unchanged.
REQ-015 In IDLE with pending_o > 0, the state SHALL move to HIGH at the next edge, and pending_o SHALL decrement at that edge.
REQ-016 HIGH SHALL last exactly HIGH_CYC cycles, then move to GAP.
REQ-017 GAP SHALL last exactly GAP_CYC cycles.
REQ-018 At the end of GAP, the state SHALL move to HIGH if pending_o > 0 or pulse_i = 1; otherwise it SHALL move to IDLE.
REQ-019 Entering HIGH from a pending request SHALL decrement pending_o.
REQ-020 A pulse_i that is not consumed at the same edge SHALL increment pending_o.
REQ-021 A simultaneous increment and decrement SHALL leave pending_o unchanged.
REQ-022 When pending_o = 2^QW-1 and an increment is required without a simultaneous decrement, the pulse SHALL be dropped, pending_o SHALL hold, and ovf_o SHALL be set.
REQ-023 ovf_o SHALL stay set until clr_i or reset.
REQ-024 pending_o SHALL never wrap.
REQ-025 clr_i = 1 SHALL force state to IDLE, level_o to 0, pending_o to 0 and ovf_o to 0 at the next edge, regardless of state.
REQ-026 A pulse_i sampled at the same edge as clr_i = 1 SHALL be discarded, because clr_i has priority.

Reset
REQ-027 rst_n = 0 SHALL immediately and asynchronously force state to IDLE, level_o to 0, busy_o to 0, pending_o to 0, ovf_o to 0, and all phase counters to 0.
REQ-028 Reset asserted in the middle of a HIGH or GAP phase SHALL abandon that phase and lose all pending requests.
REQ-029 After rst_n deasserts, the first edge SHALL behave as in IDLE.

Configuration
REQ-030 Macro PULSE_STRETCH_EDGE_EN SHALL select the request mode for pulse_i.
REQ-031 When PULSE_STRETCH_EDGE_EN is defined, pulse_i SHALL be treated as a level, and only a registered 0-to-1 transition SHALL count as a request.
REQ-032 In edge mode, a level held high for any number of cycles SHALL yield exactly one request, and latency to level_o SHALL increase by 1 cycle.
REQ-033 When PULSE_STRETCH_EDGE_EN is not defined, every cycle with pulse_i = 1 SHALL count as one request.

Structure
REQ-034 A shared package pulse_stretch_pkg SHALL hold the state enum (IDLE, HIGH, GAP) and the default parameter constants.
REQ-035 A sub-module edge_det SHALL provide the rising-edge detection (clk, rst_n, d, rise), and SHALL be instantiated only when PULSE_STRETCH_EDGE_EN is defined.
REQ-036 The phase counter width SHALL be sized from max(HIGH_CYC, GAP_CYC).

Verification
REQ-037 Defaults, pulse mode: pulse_i at edge 0 only -> level_o = 1 after edges 1-4, 0 after edges 5-6, busy_o = 0 from edge 7.
REQ-038 Defaults, pulse mode: pulse_i at edges 0, 1 and 2 -> pending_o reaches 2, level_o is high after edges 1-4, 7-10 and 13-16, and ovf_o stays 0.
REQ-039 Defaults, pulse mode: pulse_i for 6 consecutive edges starting at edge 0 -> pending_o saturates at 3, ovf_o = 1, 4 high phases in total, and pending_o never wraps.
REQ-040 Defaults, pulse mode: rst_n driven low during a HIGH phase -> level_o, busy_o and pending_o drop to 0 before the next clk edge.
REQ-041 Defaults, pulse mode: pending_o = 2, ovf_o = 1, with clr_i and pulse_i both 1 -> at the next edge state is IDLE and level_o, pending_o and ovf_o are all 0.
REQ-042 Defaults, PULSE_STRETCH_EDGE_EN defined: pulse_i held high for 10 cycles -> exactly one 4-cycle high phase on level_o and pending_o stays 0.
